// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: one accepted access per cycle,
// read data returned two cycles after acceptance. Build macro MEM_ARBITER_ROUND_ROBIN_EN selects round-robin.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [0:15] addr0,
    input  logic [0:15] addr1,
    input  logic [0:15] wdata0,
    input  logic [0:15] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [0:15] rdata0,
    output logic [0:15] rdata1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [0:15] mem_addr,
    output logic [0:15] mem_in,
    output logic        mem_load,
    input  logic [0:15] mem_out
);

    logic        pick1;
    logic        acc_vld_q,   acc_vld_d;
    logic        acc_we_q,    acc_we_d;
    logic        acc_port_q,  acc_port_d;
    logic [0:15] acc_addr_q,  acc_addr_d;
    logic [0:15] acc_wdata_q, acc_wdata_d;
    logic        rvalid0_q,   rvalid0_d;
    logic        rvalid1_q,   rvalid1_d;
    logic [0:15] rdata0_q,    rdata0_d;
    logic [0:15] rdata1_q,    rdata1_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // prio_q names the port that wins the next contention; it flips away from each accepted port
    logic prio_q, prio_d;

    assign pick1  = prio_q;
    assign prio_d = (gnt0 | gnt1) ? gnt0 : prio_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign pick1 = 1'b0;
`endif

    assign gnt0 = ~reset & req0 & (~req1 | ~pick1);
    assign gnt1 = ~reset & req1 & (~req0 |  pick1);

    always_comb begin
        acc_vld_d   = gnt0 | gnt1;
        acc_port_d  = gnt1;
        acc_we_d    = acc_we_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        if (gnt0) begin
            acc_we_d    = we0;
            acc_addr_d  = addr0;
            acc_wdata_d = wdata0;
        end else if (gnt1) begin
            acc_we_d    = we1;
            acc_addr_d  = addr1;
            acc_wdata_d = wdata1;
        end
    end

    always_comb begin
        rvalid0_d = acc_vld_q & ~acc_we_q & ~acc_port_q;
        rvalid1_d = acc_vld_q & ~acc_we_q &  acc_port_q;
        rdata0_d  = rvalid0_d ? mem_out : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_out : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_vld_q   <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_port_q  <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            acc_vld_q   <= acc_vld_d;
            acc_we_q    <= acc_we_d;
            acc_port_q  <= acc_port_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // Outputs are masked by reset so an access in flight when reset rises never reaches memory
    assign mem_load = ~reset & acc_vld_q & acc_we_q;
    assign mem_addr = (~reset & acc_vld_q) ? acc_addr_q  : '0;
    assign mem_in   = (~reset & acc_vld_q) ? acc_wdata_q : '0;
    assign rvalid0  = ~reset & rvalid0_q;
    assign rvalid1  = ~reset & rvalid1_q;
    assign rdata0   = reset ? '0 : rdata0_q;
    assign rdata1   = reset ? '0 : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written reset sequences, then random traffic
// against a transaction-level model. Honours MEM_ARBITER_ROUND_ROBIN_EN like the design.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int NR = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [0:15] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [0:15] rdata0, rdata1;
    logic        rvalid0, rvalid1;
    logic [0:15] mem_addr, mem_in, mem_out;
    logic        mem_load;

    logic [15:0] env_mem [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_load(mem_load),
        .mem_out(mem_out)
    );

    assign mem_out = env_mem[mem_addr];
    always @(posedge clk) if (mem_load) env_mem[mem_addr] <= mem_in;

    typedef struct {
        bit rst, r0, r1, w0, w1;
        logic [15:0] a0, a1, d0, d1;
        bit g0, g1, ml;
        logic [15:0] ma, mi;
        bit v0, v1;
        logic [15:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(bit rst, bit r0, bit r1, bit w0, bit w1,
                                logic [15:0] a0, logic [15:0] a1, logic [15:0] d0, logic [15:0] d1,
                                bit g0, bit g1, bit ml, logic [15:0] ma, logic [15:0] mi,
                                bit v0, bit v1, logic [15:0] rd0, logic [15:0] rd1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.ml = ml; v.ma = ma; v.mi = mi;
        v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        @(posedge clk);
        #1;
        reset = rst; req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(negedge clk);
    endtask

    vec_t tbl [18];

    // random-phase model state
    logic [15:0] mmem [0:7];
    bit          e_ml [NR+6];
    logic [15:0] e_ma [NR+6];
    logic [15:0] e_mi [NR+6];
    bit          e_rv [2][NR+6];
    logic [15:0] e_rd [2][NR+6];
    logic [15:0] hold_rd [2];
    bit          p_r [2];
    bit          p_w [2];
    logic [15:0] p_a [2];
    logic [15:0] p_d [2];
    bit          held [2];
    int          last_acc;
    int          win;

    initial begin
        for (int i = 0; i < 65536; i++) env_mem[i] = 16'h0;
        reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        tbl[0]  = mk(1,0,0,0,0, 0,0,0,0,                      0,0,0, 0,0, 0,0, 0,0);
        tbl[1]  = mk(0,1,0,1,0, 16'h10,0,16'h1234,0,          1,0,0, 0,0, 0,0, 0,0);
        tbl[2]  = mk(0,0,0,0,0, 0,0,0,0,                      0,0,1, 16'h10,16'h1234, 0,0, 0,0);
        tbl[3]  = mk(0,0,1,0,0, 0,16'h10,0,0,                 0,1,0, 0,0, 0,0, 0,0);
        tbl[4]  = mk(0,0,0,0,0, 0,0,0,0,                      0,0,0, 16'h10,0, 0,0, 0,0);
        tbl[5]  = mk(0,0,0,0,0, 0,0,0,0,                      0,0,0, 0,0, 0,1, 0,16'h1234);
        tbl[6]  = mk(0,0,0,0,0, 0,0,0,0,                      0,0,0, 0,0, 0,0, 0,16'h1234);
        tbl[7]  = mk(0,1,0,1,0, 16'h20,0,16'hBEEF,0,          1,0,0, 0,0, 0,0, 0,16'h1234);
        tbl[8]  = mk(0,1,0,0,0, 16'h20,0,0,0,                 1,0,1, 16'h20,16'hBEEF, 0,0, 0,16'h1234);
        tbl[9]  = mk(0,0,0,0,0, 0,0,0,0,                      0,0,0, 16'h20,0, 0,0, 0,16'h1234);
        tbl[10] = mk(0,0,0,0,0, 0,0,0,0,                      0,0,0, 0,0, 1,0, 16'hBEEF,16'h1234);
        tbl[11] = mk(0,0,1,0,0, 0,16'h10,0,0,                 0,1,0, 0,0, 0,0, 16'hBEEF,16'h1234);
        tbl[12] = mk(0,1,1,1,1, 16'h40,16'h41,16'h1111,16'h2222, 1,0,0, 16'h10,0, 0,0, 16'hBEEF,16'h1234);
        tbl[13] = mk(0,1,1,1,1, 16'h40,16'h41,16'h1111,16'h2222, !RR,RR,1, 16'h40,16'h1111, 0,1, 16'hBEEF,16'h1234);
        tbl[14] = mk(0,1,1,1,1, 16'h40,16'h41,16'h1111,16'h2222, 1,0,1,
                     RR ? 16'h41 : 16'h40, RR ? 16'h2222 : 16'h1111, 0,0, 16'hBEEF,16'h1234);
        tbl[15] = mk(0,1,1,1,1, 16'h40,16'h41,16'h1111,16'h2222, !RR,RR,1, 16'h40,16'h1111, 0,0, 16'hBEEF,16'h1234);
        tbl[16] = mk(0,0,0,0,0, 0,0,0,0,                      0,0,1,
                     RR ? 16'h41 : 16'h40, RR ? 16'h2222 : 16'h1111, 0,0, 16'hBEEF,16'h1234);
        tbl[17] = mk(0,0,0,0,0, 0,0,0,0,                      0,0,0, 0,0, 0,0, 16'hBEEF,16'h1234);

        drive(1,0,0,0,0,0,0,0,0);
        drive(1,0,0,0,0,0,0,0,0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1,
                  tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            chk($sformatf("tbl%0d gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
            chk($sformatf("tbl%0d gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
            chk($sformatf("tbl%0d mem_load", i), 32'(mem_load), 32'(tbl[i].ml));
            chk($sformatf("tbl%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].ma));
            chk($sformatf("tbl%0d mem_in", i), 32'(mem_in), 32'(tbl[i].mi));
            chk($sformatf("tbl%0d rvalid0", i), 32'(rvalid0), 32'(tbl[i].v0));
            chk($sformatf("tbl%0d rvalid1", i), 32'(rvalid1), 32'(tbl[i].v1));
            chk($sformatf("tbl%0d rdata0", i), 32'(rdata0), 32'(tbl[i].rd0));
            chk($sformatf("tbl%0d rdata1", i), 32'(rdata1), 32'(tbl[i].rd1));
        end

        // write to 0x0030 killed by reset during its access cycle
        drive(0,1,0,1,0, 16'h30,0,16'h5555,0);
        chk("wr30 gnt0", 32'(gnt0), 32'd1);
        drive(1,0,0,0,0, 0,0,0,0);
        chk("wr30 reset mem_load", 32'(mem_load), 32'd0);
        chk("wr30 reset mem_addr", 32'(mem_addr), 32'd0);
        chk("wr30 reset gnt0", 32'(gnt0), 32'd0);
        drive(0,0,0,0,0, 0,0,0,0);
        chk("wr30 post mem_load", 32'(mem_load), 32'd0);
        chk("wr30 post rvalid0", 32'(rvalid0), 32'd0);
        chk("wr30 post rvalid1", 32'(rvalid1), 32'd0);
        chk("wr30 post rdata0", 32'(rdata0), 32'd0);
        chk("wr30 post rdata1", 32'(rdata1), 32'd0);
        chk("mem 0030 unchanged", 32'(env_mem[16'h30]), 32'd0);

        // read killed by reset, then contention in the first cycle out of reset
        drive(0,0,1,0,0, 0,16'h10,0,0);
        chk("rdkill gnt1", 32'(gnt1), 32'd1);
        drive(1,0,0,0,0, 0,0,0,0);
        chk("rdkill reset rvalid1", 32'(rvalid1), 32'd0);
        drive(0,1,1,0,0, 16'h20,16'h10,0,0);
        chk("rdkill post rvalid1", 32'(rvalid1), 32'd0);
        chk("post-reset gnt0", 32'(gnt0), 32'd1);
        chk("post-reset gnt1", 32'(gnt1), 32'd0);
        drive(0,1,1,0,0, 16'h20,16'h10,0,0);
        chk("post-reset 2nd gnt0", 32'(gnt0), 32'(!RR));
        chk("post-reset 2nd gnt1", 32'(gnt1), 32'(RR));
        chk("post-reset 2nd rvalid1", 32'(rvalid1), 32'd0);
        chk("post-reset mem_addr", 32'(mem_addr), 32'h20);
        drive(0,0,0,0,0, 0,0,0,0);
        chk("post-reset rvalid0", 32'(rvalid0), 32'd1);
        chk("post-reset rdata0", 32'(rdata0), 32'hBEEF);
        drive(0,0,0,0,0, 0,0,0,0);
        drive(0,0,0,0,0, 0,0,0,0);

        // random traffic against a transaction-level model
        drive(1,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 8; i++) mmem[i] = 16'h0;
        for (int c = 0; c < NR+6; c++) begin
            e_ml[c] = 0; e_ma[c] = 0; e_mi[c] = 0;
            for (int p = 0; p < 2; p++) begin e_rv[p][c] = 0; e_rd[p][c] = 0; end
        end
        for (int p = 0; p < 2; p++) begin hold_rd[p] = 0; held[p] = 0; p_r[p] = 0; end
        last_acc = 1;

        for (int c = 0; c < NR+3; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!held[p]) begin
                    if (c < NR && $urandom_range(0, 9) < 6) begin
                        p_r[p] = 1;
                        p_w[p] = 1'($urandom_range(0, 1));
                        p_a[p] = 16'h100 + 16'($urandom_range(0, 7));
                        p_d[p] = 16'($urandom);
                    end else begin
                        p_r[p] = 0; p_w[p] = 0; p_a[p] = 0; p_d[p] = 0;
                    end
                end
            end
            if (p_r[0] && p_r[1]) win = RR ? 1 - last_acc : 0;
            else if (p_r[0]) win = 0;
            else if (p_r[1]) win = 1;
            else win = -1;

            drive(0, p_r[0], p_r[1], p_w[0], p_w[1], p_a[0], p_a[1], p_d[0], p_d[1]);
            chk("rnd gnt0", 32'(gnt0), 32'(win == 0));
            chk("rnd gnt1", 32'(gnt1), 32'(win == 1));
            chk("rnd mem_load", 32'(mem_load), 32'(e_ml[c]));
            chk("rnd mem_addr", 32'(mem_addr), 32'(e_ma[c]));
            chk("rnd mem_in", 32'(mem_in), 32'(e_mi[c]));
            for (int p = 0; p < 2; p++) if (e_rv[p][c]) hold_rd[p] = e_rd[p][c];
            chk("rnd rvalid0", 32'(rvalid0), 32'(e_rv[0][c]));
            chk("rnd rvalid1", 32'(rvalid1), 32'(e_rv[1][c]));
            chk("rnd rdata0", 32'(rdata0), 32'(hold_rd[0]));
            chk("rnd rdata1", 32'(rdata1), 32'(hold_rd[1]));

            if (win >= 0) begin
                last_acc = win;
                e_ml[c+1] = p_w[win];
                e_ma[c+1] = p_a[win];
                e_mi[c+1] = p_d[win];
                if (p_w[win]) begin
                    mmem[p_a[win] - 16'h100] = p_d[win];
                end else begin
                    e_rv[win][c+2] = 1;
                    e_rd[win][c+2] = mmem[p_a[win] - 16'h100];
                end
            end
            for (int p = 0; p < 2; p++) held[p] = p_r[p] && (win != p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
